// File: rtl/rr_arb_mux_if.sv
// Handshake bundle for rr_arb_mux: N input channels with valid/ready and one
// registered output channel. The in_last wires exist only when the build
// defines RR_ARB_MUX_LOCK_EN.
interface rr_arb_mux_if #(
  parameter int N = 4,
  parameter int W = 32
);
  localparam int SELW = $clog2(N);

  logic [N-1:0]    in_valid;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_ready;
`ifdef RR_ARB_MUX_LOCK_EN
  logic [N-1:0]    in_last;
`endif
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [SELW-1:0] out_src;
  logic            out_ready;

  // Arbiter side: consumes requests, produces the merged stream
  modport slave (
    input  in_valid,
    input  in_data,
`ifdef RR_ARB_MUX_LOCK_EN
    input  in_last,
`endif
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_src
  );

  // Requester/sink side
  modport master (
    output in_valid,
    output in_data,
`ifdef RR_ARB_MUX_LOCK_EN
    output in_last,
`endif
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_src
  );
endinterface

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-to-1 W-bit mux with a round-robin arbiter and a single
// registered output stage (1 beat/cycle sustained, 1 cycle latency).
// Optional feature macro: RR_ARB_MUX_LOCK_EN -- when defined, a beat accepted
// with in_last=0 locks the arbiter onto that channel until its in_last=1 beat.
module rr_arb_mux #(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  rr_arb_mux_if.slave bus
);
  localparam int SELW = $clog2(N);

  logic [SELW-1:0] last_gnt_r;
  logic            out_valid_r;
  logic [W-1:0]    out_data_r;
  logic [SELW-1:0] out_src_r;

  logic            load_s;
  logic            accept_s;
  logic            gnt_found_s;
  logic [SELW-1:0] gnt_idx_s;
  logic [W-1:0]    gnt_data_s;
  logic [N-1:0]    in_ready_s;
  int              cand_s;
  logic [SELW-1:0] cand_idx_s;
  logic            elig_s;

`ifdef RR_ARB_MUX_LOCK_EN
  logic            lock_r;
  logic [SELW-1:0] lock_ch_r;
`endif

  // The output register can take a new beat when empty or being drained
  assign load_s   = !out_valid_r || bus.out_ready;
  assign accept_s = gnt_found_s && load_s;

  // Rotating-priority search starting just after the last winner
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_idx_s   = {SELW{1'b0}};
    cand_s      = 0;
    cand_idx_s  = {SELW{1'b0}};
    elig_s      = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand_s     = (int'(last_gnt_r) + k) % N;
      cand_idx_s = SELW'(cand_s);
`ifdef RR_ARB_MUX_LOCK_EN
      elig_s = bus.in_valid[cand_idx_s] && (!lock_r || (cand_idx_s == lock_ch_r));
`else
      elig_s = bus.in_valid[cand_idx_s];
`endif
      if (elig_s && !gnt_found_s) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = cand_idx_s;
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
  end

  // Select the granted lane's data (constant indices keep the mux explicit)
  always_comb begin
    gnt_data_s = {W{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (gnt_idx_s == SELW'(i)) begin
        gnt_data_s = bus.in_data[i*W +: W];
      end else begin
        gnt_data_s = gnt_data_s;
      end
    end
  end

  // One-hot ready to the winner only; forced low while reset is asserted
  always_comb begin
    in_ready_s = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      in_ready_s[i] = accept_s && rst_n && (gnt_idx_s == SELW'(i));
    end
  end

  // Output stage and arbitration pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {W{1'b0}};
      out_src_r   <= {SELW{1'b0}};
      last_gnt_r  <= SELW'(N - 1);
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= gnt_data_s;
      out_src_r   <= gnt_idx_s;
      last_gnt_r  <= gnt_idx_s;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

`ifdef RR_ARB_MUX_LOCK_EN
  // Packet lock: hold the grant on a channel until its last beat is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_r    <= 1'b0;
      lock_ch_r <= {SELW{1'b0}};
    end else if (accept_s) begin
      lock_r    <= !bus.in_last[gnt_idx_s];
      lock_ch_r <= gnt_idx_s;
    end
  end
`endif

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_src   = out_src_r;
endmodule
